// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-port block RAM arbiter: lock state and port-select codes.
package bram_arbiter_pkg;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned STRB_WIDTH = 4;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      LOCKED_B = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_A    = 2'd1,
      SEL_B    = 2'd2
   } port_sel_e;
endpackage

// File: rtl/bram_arb_rsp.sv
// Read-response steering: remembers which port issued the read that the RAM
// answers this cycle and routes BRAM_RDATA to that port with its RVALID.
module bram_arb_rsp
   import bram_arbiter_pkg::*;
(
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  port_sel_e             grant_sel,
   input  logic                  grant_read,
   input  logic [DATA_WIDTH-1:0] BRAM_RDATA,
   output logic                  A_RVALID,
   output logic [DATA_WIDTH-1:0] A_RDATA,
   output logic                  B_RVALID,
   output logic [DATA_WIDTH-1:0] B_RDATA
);

   port_sel_e rd_src_r;

   // Capture the owner of next cycle's RAM read data
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rd_src_r <= SEL_NONE;
      end else if (grant_read) begin
         rd_src_r <= grant_sel;
      end else begin
         rd_src_r <= SEL_NONE;
      end
   end

   // Steer read data; reset also masks a read whose data is still in flight
   always_comb begin
      A_RVALID = 1'b0;
      B_RVALID = 1'b0;
      A_RDATA  = 32'h0000_0000;
      B_RDATA  = 32'h0000_0000;
      if (HRESET) begin
         A_RVALID = 1'b0;
         B_RVALID = 1'b0;
      end else begin
         case (rd_src_r)
            SEL_A: begin
               A_RVALID = 1'b1;
               A_RDATA  = BRAM_RDATA;
            end
            SEL_B: begin
               B_RVALID = 1'b1;
               B_RDATA  = BRAM_RDATA;
            end
            default: begin
               A_RVALID = 1'b0;
               B_RVALID = 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/bram_arbiter.sv
// Two-master arbiter for a single-port block RAM: A has priority, B can lock.
// Optional starvation guard for port B is enabled by defining BRAM_ARB_STARVE_EN.
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 14,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  A_REQ,
   input  logic [ADDR_WIDTH-1:0] A_ADDR,
   input  logic [DATA_WIDTH-1:0] A_WDATA,
   input  logic [STRB_WIDTH-1:0] A_WE,
   output logic                  A_GNT,
   output logic                  A_RVALID,
   output logic [DATA_WIDTH-1:0] A_RDATA,
   input  logic                  B_REQ,
   input  logic [ADDR_WIDTH-1:0] B_ADDR,
   input  logic [DATA_WIDTH-1:0] B_WDATA,
   input  logic [STRB_WIDTH-1:0] B_WE,
   input  logic                  B_LOCK,
   output logic                  B_GNT,
   output logic                  B_RVALID,
   output logic [DATA_WIDTH-1:0] B_RDATA,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic [DATA_WIDTH-1:0] BRAM_WDATA,
   output logic [STRB_WIDTH-1:0] BRAM_WRITE,
   input  logic [DATA_WIDTH-1:0] BRAM_RDATA
);

   arb_state_e state_r;
   arb_state_e next_state_s;
   port_sel_e  sel_s;
   logic       starve_hit_s;
   logic       grant_read_s;

   if (STARVE_LIMIT < 32'd1) begin : g_limit_check
      $error("bram_arbiter: STARVE_LIMIT must be at least 1");
   end

`ifdef BRAM_ARB_STARVE_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 32'd1);
   logic [CNT_W-1:0] starve_cnt_r;

   assign starve_hit_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));

   // Count consecutive denied B cycles, saturating at the limit
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (!B_REQ || B_GNT) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (!starve_hit_s) begin
         starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end
`else
   assign starve_hit_s = 1'b0;
`endif

   // Lock state register
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Lock holds while B keeps requesting and its granted accesses keep B_LOCK set
   always_comb begin
      next_state_s = state_r;
      if (HRESET) begin
         next_state_s = IDLE;
      end else if (!B_REQ) begin
         next_state_s = IDLE;
      end else if (B_GNT) begin
         next_state_s = B_LOCK ? LOCKED_B : IDLE;
      end else begin
         next_state_s = state_r;
      end
   end

   // Pick the winner and drive the RAM from its fields
   always_comb begin
      sel_s      = SEL_NONE;
      A_GNT      = 1'b0;
      B_GNT      = 1'b0;
      BRAM_ADDR  = {ADDR_WIDTH{1'b0}};
      BRAM_WDATA = 32'h0000_0000;
      BRAM_WRITE = 4'h0;
      if (HRESET) begin
         sel_s = SEL_NONE;
      end else if (B_REQ && ((state_r == LOCKED_B) || starve_hit_s)) begin
         sel_s = SEL_B;
      end else if (A_REQ) begin
         sel_s = SEL_A;
      end else if (B_REQ) begin
         sel_s = SEL_B;
      end else begin
         sel_s = SEL_NONE;
      end
      case (sel_s)
         SEL_A: begin
            A_GNT      = 1'b1;
            BRAM_ADDR  = A_ADDR;
            BRAM_WDATA = A_WDATA;
            BRAM_WRITE = A_WE;
         end
         SEL_B: begin
            B_GNT      = 1'b1;
            BRAM_ADDR  = B_ADDR;
            BRAM_WDATA = B_WDATA;
            BRAM_WRITE = B_WE;
         end
         default: begin
            A_GNT = 1'b0;
            B_GNT = 1'b0;
         end
      endcase
   end

   assign grant_read_s = (sel_s != SEL_NONE) && (BRAM_WRITE == 4'h0);

   bram_arb_rsp u_rsp (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .grant_sel  (sel_s),
      .grant_read (grant_read_s),
      .BRAM_RDATA (BRAM_RDATA),
      .A_RVALID   (A_RVALID),
      .A_RDATA    (A_RDATA),
      .B_RVALID   (B_RVALID),
      .B_RDATA    (B_RDATA)
   );
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, word-address width of the shared block RAM.
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive denied cycles of port B before forced grant (used only with BRAM_ARB_STARVE_EN).
REQ-003 HCLK  in  1  single clock; all state updates on rising edge.
REQ-004 HRESET  in  1  synchronous active-high reset.
REQ-005 A_REQ  in  1  port A (bus bridge) access request; A_ADDR/A_WDATA/A_WE held stable until granted.
REQ-006 A_ADDR  in  ADDR_WIDTH  port A word address.
REQ-007 A_WDATA  in  32  port A write data.
REQ-008 A_WE  in  4  port A byte write strobes; 4'h0 means read.
REQ-009 A_GNT  out  1  port A access accepted this cycle.
REQ-010 A_RVALID  out  1  port A read data valid.
REQ-011 A_RDATA  out  32  port A read data.
REQ-012 B_REQ, B_ADDR, B_WDATA, B_WE, B_GNT, B_RVALID, B_RDATA: port B (secondary master), same widths and meanings as port A.
REQ-013 B_LOCK  in  1  port B requests uninterrupted ownership for following accesses.
REQ-014 BRAM_ADDR  out  ADDR_WIDTH  RAM word address.
REQ-015 BRAM_WDATA  out  32  RAM write data.
REQ-016 BRAM_WRITE  out  4  RAM byte write enables.
REQ-017 BRAM_RDATA  in  32  RAM read data, valid one cycle after the address is presented.

Function
REQ-018 Exactly one access reaches the RAM per cycle; x_GNT is combinational and asserted only when x_REQ is high.
REQ-019 Default priority: port A wins when both request.
REQ-020 Lock: after a granted B access with B_LOCK=1, state LOCKED_B; in LOCKED_B port B wins over A; exit to IDLE on a granted B access with B_LOCK=0 or any cycle with B_REQ=0.
REQ-021 Granted port drives BRAM_ADDR/BRAM_WDATA/BRAM_WRITE from its own fields the same cycle; with no grant BRAM_WRITE=4'h0, BRAM_ADDR=0, BRAM_WDATA=0.
REQ-022 Read latency: granted read (WE=0) in cycle N gives x_RVALID=1 in cycle N+1 only, x_RDATA=BRAM_RDATA; writes produce no RVALID.
REQ-023 x_RDATA is 32'h0 whenever x_RVALID=0.
REQ-024 Back-to-back grants to the same or alternate ports allowed every cycle; read of an address written the previous cycle returns the new data (RAM write-first).
REQ-025 Simultaneous A_RVALID and B_RVALID is impossible; at most one RVALID per cycle.

Reset
REQ-026 While HRESET=1: A_GNT=B_GNT=0, BRAM_WRITE=0, both RVALID=0, state IDLE, starvation counter 0; requests ignored.
REQ-027 Reset asserted with a read in flight discards its RVALID; first grant possible in the first cycle with HRESET=0.

Configuration
REQ-028 Macro BRAM_ARB_STARVE_EN defined: counter of consecutive cycles with B_REQ=1 and B_GNT=0; when it reaches STARVE_LIMIT, B wins the next cycle regardless of A; counter clears on B grant or B_REQ=0.
REQ-029 Macro undefined: no counter logic; port B may wait indefinitely while A requests (outside LOCKED_B).

Structure
REQ-030 Shared package holds the state enumeration (IDLE, LOCKED_B) and port-select constants (SEL_NONE, SEL_A, SEL_B).
REQ-031 One sub-module bram_arb_rsp: registers granted-read source and muxes BRAM_RDATA to the correct port with RVALID.

Verification
REQ-032 A read 0x010 alone -> A_GNT same cycle, A_RVALID next cycle with RAM content of 0x010, B_RVALID=0.
REQ-033 A and B both request every cycle, no lock, macro off -> A granted every cycle, B_GNT=0 throughout.
REQ-034 Same stimulus, macro on, STARVE_LIMIT=8 -> B_GNT on every 9th cycle, A denied that cycle.
REQ-035 B write 0x5 data 32'hDEADBEEF WE=4'hF with B_LOCK=1 then three more B accesses with lock, A requesting -> A_GNT=0 until the cycle after B access with B_LOCK=0.
REQ-036 A write WE=4'h1 data 32'h000000AA to 0x20 then B read 0x20 next cycle -> B_RDATA low byte 8'hAA.
REQ-037 HRESET pulsed the cycle after a granted read -> no RVALID on either port; grant accepted first cycle after release.
